// File: rtl/dct_sequencer.sv
// dct_sequencer: control FSM for a row/column 2D DCT built around a single 1D DCT core.
// Eight row passes, then eight column passes over an 8x8 RAM block, with a watchdog on done2.
module dct_sequencer #(
   parameter int DONE_TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic isCt17,
   input  logic isCt27,
   input  logic isCt37,
   input  logic done2,
   output logic rstCt1,
   output logic rstCt2,
   output logic rstCt3,
   output logic incCt1,
   output logic incCt2,
   output logic incCt3,
   output logic setCt2,
   output logic setCt3,
   output logic clrReg,
   output logic clrRAM,
   output logic cs,
   output logic read,
   output logic write,
   output logic enROM,
   output logic enDecoder,
   output logic enDCT,
   output logic loadOutReg,
   output logic start2,
   output logic multiplexed_input,
   output logic transpose,
   output logic busy,
   output logic done,
   output logic err
);
   localparam int TW = $clog2(DONE_TIMEOUT + 1);

   localparam logic [3:0] IDLE  = 4'd0;
   localparam logic [3:0] INIT  = 4'd1;
   localparam logic [3:0] RD    = 4'd2;
   localparam logic [3:0] KICK  = 4'd3;
   localparam logic [3:0] WAIT  = 4'd4;
   localparam logic [3:0] LDOUT = 4'd5;
   localparam logic [3:0] WR    = 4'd6;
   localparam logic [3:0] NEXT  = 4'd7;
   localparam logic [3:0] DONE  = 4'd8;
   localparam logic [3:0] ERR   = 4'd9;

   logic [3:0]    state_q, state_d;
   logic          pass_q, pass_d;
   logic [TW-1:0] to_q, to_d;

   // The register-select counter moves in lockstep with the column counter, so its flag is not needed.
   logic unused_isct37;
   assign unused_isct37 = isCt37;

   always_comb begin
      state_d = state_q;
      pass_d  = pass_q;
      to_d    = to_q;
      case (state_q)
         IDLE:  if (start) state_d = INIT;
         INIT: begin
            pass_d  = 1'b0;
            state_d = RD;
         end
         RD:    if (isCt27) state_d = KICK;
         KICK: begin
            to_d    = '0;
            state_d = WAIT;
         end
         // done2 is checked before the limit so a coincident completion is never flagged as an error.
         WAIT: begin
            if (done2) begin
               state_d = LDOUT;
            end else if (to_q == TW'(DONE_TIMEOUT - 1)) begin
               state_d = ERR;
            end else begin
               to_d = to_q + TW'(1);
            end
         end
         LDOUT: state_d = WR;
         WR:    if (isCt27) state_d = NEXT;
         NEXT: begin
            if (!isCt17) begin
               state_d = RD;
            end else if (!pass_q) begin
               pass_d  = 1'b1;
               state_d = RD;
            end else begin
               state_d = DONE;
            end
         end
         DONE:  if (start) state_d = INIT;
         ERR:   if (start) state_d = INIT;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pass_q  <= 1'b0;
         to_q    <= '0;
      end else begin
         state_q <= state_d;
         pass_q  <= pass_d;
         to_q    <= to_d;
      end
   end

   always_comb begin
      rstCt1 = 1'b0;  rstCt2 = 1'b0;  rstCt3 = 1'b0;
      incCt1 = 1'b0;  incCt2 = 1'b0;  incCt3 = 1'b0;
      setCt2 = 1'b0;  setCt3 = 1'b0;
      clrReg = 1'b0;  clrRAM = 1'b0;
      cs = 1'b0;  read = 1'b0;  write = 1'b0;
      enROM = 1'b0;  enDecoder = 1'b0;  enDCT = 1'b0;
      loadOutReg = 1'b0;  start2 = 1'b0;
      busy = 1'b0;  done = 1'b0;  err = 1'b0;
      case (state_q)
         INIT: begin
            busy = 1'b1;
            rstCt1 = 1'b1;  rstCt2 = 1'b1;  rstCt3 = 1'b1;
            clrReg = 1'b1;
         end
         RD: begin
            busy = 1'b1;
            cs = 1'b1;  read = 1'b1;  enDecoder = 1'b1;
            incCt2 = 1'b1;  incCt3 = 1'b1;
         end
         KICK: begin
            busy = 1'b1;
            start2 = 1'b1;  enDCT = 1'b1;  enROM = 1'b1;
         end
         WAIT: begin
            busy = 1'b1;
            enDCT = 1'b1;  enROM = 1'b1;
         end
         LDOUT: begin
            busy = 1'b1;
            loadOutReg = 1'b1;  rstCt2 = 1'b1;  rstCt3 = 1'b1;
         end
         WR: begin
            busy = 1'b1;
            cs = 1'b1;  write = 1'b1;  enDecoder = 1'b1;
            incCt2 = 1'b1;  incCt3 = 1'b1;
         end
         NEXT: begin
            busy = 1'b1;
            clrReg = 1'b1;  rstCt2 = 1'b1;  rstCt3 = 1'b1;
            incCt1 = !isCt17;
            rstCt1 = isCt17 && !pass_q;
         end
         DONE: done = 1'b1;
         ERR:  err  = 1'b1;
         default: ;
      endcase
      // The RAM bus belongs to the outside world when idle, so the address swap only applies while busy.
      multiplexed_input = busy;
      transpose         = busy && pass_q;
   end
endmodule

// File: doc/dct_sequencer.md
DCT_SEQUENCER -- requirements
Module: dct_sequencer

Interface
REQ-001 SHALL have parameter DONE_TIMEOUT, default 64: maximum cycles to wait for done2 after start2.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request one full 2D transform; sampled in IDLE, DONE or ERR only.
REQ-005 SHALL have port isCt17, isCt27, isCt37  input  1 each  row, col and register-select counters equal 7.
REQ-006 SHALL have port done2  input  1  1D DCT core finished.
REQ-007 SHALL have port rstCt1, rstCt2, rstCt3, incCt1, incCt2, incCt3, setCt2, setCt3  output  1 each  counter controls.
REQ-008 SHALL have port clrReg, clrRAM, cs, read, write, enROM, enDecoder, enDCT, loadOutReg, start2  output  1 each  datapath controls.
REQ-009 SHALL have port multiplexed_input  output  1  0 = testbench owns RAM bus, 1 = datapath owns it.
REQ-010 SHALL have port transpose  output  1  swaps RAM address to {col,row} (column pass).
REQ-011 SHALL have ports busy, done, err  output  1 each  status flags.

Function
REQ-012 SHALL implement states IDLE, INIT, RD, KICK, WAIT, LDOUT, WR, NEXT, DONE, ERR.
REQ-013 IDLE: all outputs 0; start=1 -> INIT.
REQ-014 INIT (1 cycle): rstCt1=rstCt2=rstCt3=1, clrReg=1, pass bit cleared -> RD.
REQ-015 RD (exactly 8 cycles): cs=read=enDecoder=1, incCt2=incCt3=1; leave to KICK on the cycle isCt27=1.
REQ-016 KICK (1 cycle): start2=1, enDCT=enROM=1, timeout counter cleared -> WAIT.
REQ-017 WAIT: enDCT=enROM=1 held; done2=1 -> LDOUT; DONE_TIMEOUT cycles without done2 -> ERR.
REQ-018 LDOUT (1 cycle): loadOutReg=1, rstCt2=rstCt3=1 -> WR.
REQ-019 WR (exactly 8 cycles): cs=write=enDecoder=1, incCt2=incCt3=1; leave to NEXT on the cycle isCt27=1.
REQ-020 NEXT (1 cycle): clrReg=1, rstCt2=rstCt3=1; if isCt17=0: incCt1=1 -> RD; if isCt17=1 and pass=0: rstCt1=1, pass<=1 -> RD; if isCt17=1 and pass=1 -> DONE.
REQ-021 multiplexed_input SHALL be 1 in INIT through NEXT and 0 in IDLE, DONE, ERR.
REQ-022 transpose SHALL equal the pass bit; 0 for the row pass, 1 for the column pass.
REQ-023 busy SHALL be 1 in INIT through NEXT.
REQ-024 DONE: done=1 held; start=1 -> INIT, clearing done.
REQ-025 ERR: err=1 held, busy=0; start=1 -> INIT, clearing err.
REQ-026 start asserted while busy SHALL be ignored.
REQ-027 done2 outside WAIT SHALL be ignored; done2 on the same cycle as the timeout limit SHALL win (-> LDOUT).
REQ-028 setCt2, setCt3 and clrRAM SHALL remain 0 in all states (reserved for later use).
REQ-029 All outputs SHALL be registered-state decodes (Moore), free of glitches from done2 or start.
REQ-030 One transform SHALL take 2 + 16 x (19 + L) cycles from start to done, with L = cycles spent in WAIT per row.

Reset
REQ-031 rst_n=0 SHALL force state IDLE, pass=0, timeout counter 0 and every output 0, immediately and regardless of clock.
REQ-032 Reset mid-operation SHALL abandon the transform with no partial RAM write after release; first start after release -> INIT.

Verification
REQ-033 Reset then start pulse, done2 modeled 10 cycles after start2 -> done=1 exactly 2+16x29=466 cycles after start; 16 start2 pulses; 128 write strobes.
REQ-034 Sample transpose on each start2 -> 0 for the first 8, 1 for the last 8.
REQ-035 done2 never returned, DONE_TIMEOUT=64 -> err=1 exactly 65 cycles after start2; busy=0; multiplexed_input=0.
REQ-036 Extra start pulses during RD and WAIT -> no state change; single done at the REQ-033 cycle count.
REQ-037 rst_n low during WR of row 3 -> all outputs 0 within the same cycle; a new start completes normally in 466 cycles.
REQ-038 done2 coincident with the timeout cycle -> LDOUT taken, err stays 0.
